// File: rtl/plab3_mem_blocking_cache_alt_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// plab3_mem_blocking_cache_alt_ctrl_pkg: shared encodings for the cache control unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package plab3_mem_blocking_cache_alt_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE           = 4'd0,
    ST_TAG_CHECK      = 4'd1,
    ST_READ_ACCESS    = 4'd2,
    ST_WRITE_ACCESS   = 4'd3,
    ST_AMO_READ       = 4'd4,
    ST_AMO_WRITE      = 4'd5,
    ST_EVICT_PREPARE  = 4'd6,
    ST_EVICT_REQUEST  = 4'd7,
    ST_EVICT_WAIT     = 4'd8,
    ST_REFILL_REQUEST = 4'd9,
    ST_REFILL_WAIT    = 4'd10,
    ST_REFILL_UPDATE  = 4'd11,
    ST_WAIT           = 4'd12
  } state_t;

  localparam logic [2:0] C_TYPE_READ    = 3'd0;
  localparam logic [2:0] C_TYPE_WRITE   = 3'd1;
  localparam logic [2:0] C_TYPE_INIT    = 3'd2;
  localparam logic [2:0] C_TYPE_AMO_ADD = 3'd3;
  localparam logic [2:0] C_TYPE_AMO_AND = 3'd4;
  localparam logic [2:0] C_TYPE_AMO_OR  = 3'd5;

  localparam logic [1:0] C_AMO_PASS = 2'd0;
  localparam logic [1:0] C_AMO_ADD  = 2'd1;
  localparam logic [1:0] C_AMO_AND  = 2'd2;
  localparam logic [1:0] C_AMO_OR   = 2'd3;

  localparam logic [2:0] C_MEMREQ_READ  = 3'd0;
  localparam logic [2:0] C_MEMREQ_WRITE = 3'd1;

  // One 32-bit word lane within the 16-byte line.
  function automatic logic [15:0] word_wben(input logic [1:0] word);
    return 16'h000F << {word, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/plab3_mem_blocking_cache_alt_ctrl_line_state.sv
// ----------------------------------------------------------------------------
// plab3_mem_cache_line_state: per-line valid/dirty bits and per-set LRU bit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plab3_mem_cache_line_state
  import plab3_mem_blocking_cache_alt_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] idx,
  output logic [1:0] valid,
  output logic [1:0] dirty,
  output logic       lru,
  input  logic       line_wen,
  input  logic       line_way,
  input  logic       line_valid,
  input  logic       line_dirty,
  input  logic       lru_wen,
  input  logic       lru_wdata
);

  logic [7:0][1:0] valid_q, valid_d;
  logic [7:0][1:0] dirty_q, dirty_d;
  logic [7:0]      lru_q,   lru_d;

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    lru_d   = lru_q;
    if (line_wen) begin
      valid_d[idx][line_way] = line_valid;
      dirty_d[idx][line_way] = line_dirty;
    end
    if (lru_wen) begin
      lru_d[idx] = lru_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lru_q   <= lru_d;
    end
  end

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign lru   = lru_q[idx];

endmodule

`default_nettype wire

// File: rtl/plab3_mem_blocking_cache_alt_ctrl.sv
// ----------------------------------------------------------------------------
// plab3_mem_blocking_cache_alt_ctrl: FSM control for the 2-way write-back blocking cache
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module plab3_mem_blocking_cache_alt_ctrl
  import plab3_mem_blocking_cache_alt_ctrl_pkg::*;
#(
  parameter int p_idx_shamt    = 0,
  parameter int p_opaque_nbits = 8
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        cachereq_val,
  output logic        cachereq_rdy,
  output logic        cacheresp_val,
  input  logic        cacheresp_rdy,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic        memresp_val,
  output logic        memresp_rdy,
  input  logic [2:0]  cachereq_type,
  input  logic [31:0] cachereq_addr,
  input  logic        tag_match_0,
  input  logic        tag_match_1,
  output logic        cachereq_en,
  output logic        memresp_en,
  output logic        is_refill,
  output logic        read_data_reg_en,
  output logic        read_tag_reg_en,
  output logic        tag_array_0_wen,
  output logic        tag_array_0_ren,
  output logic        tag_array_1_wen,
  output logic        tag_array_1_ren,
  output logic        data_array_wen,
  output logic        data_array_ren,
  output logic        way_sel,
  output logic [15:0] data_array_wben,
  output logic [1:0]  amo_sel,
  output logic [1:0]  read_byte_sel,
  output logic [2:0]  memreq_type,
  output logic [2:0]  cacheresp_type
);

  state_t state_q, state_d;
  logic   hit_way_q, hit_way_d;
  logic   victim_q, victim_d;

  logic [2:0] idx;
  logic [1:0] line_valid_r, line_dirty_r;
  logic       lru_r;
  logic       line_wen, line_way, line_valid, line_dirty, lru_wen, lru_wdata;
  logic       hit0, hit1;

  logic                      unused_addr;
  logic [p_opaque_nbits-1:0] unused_opaque;
  assign unused_addr   = ^cachereq_addr;
  assign unused_opaque = '0;

  assign idx = cachereq_addr[4+p_idx_shamt +: 3];

  plab3_mem_cache_line_state u_line_state (
    .clk        (clk),
    .reset      (reset),
    .idx        (idx),
    .valid      (line_valid_r),
    .dirty      (line_dirty_r),
    .lru        (lru_r),
    .line_wen   (line_wen),
    .line_way   (line_way),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .lru_wen    (lru_wen),
    .lru_wdata  (lru_wdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hit_way_q <= 1'b0;
      victim_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hit_way_q <= hit_way_d;
      victim_q  <= victim_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    hit_way_d        = hit_way_q;
    victim_d         = victim_q;
    hit0             = 1'b0;
    hit1             = 1'b0;
    cachereq_rdy     = 1'b0;
    cacheresp_val    = 1'b0;
    memreq_val       = 1'b0;
    memresp_rdy      = 1'b0;
    cachereq_en      = 1'b0;
    memresp_en       = 1'b0;
    is_refill        = 1'b0;
    read_data_reg_en = 1'b0;
    read_tag_reg_en  = 1'b0;
    tag_array_0_wen  = 1'b0;
    tag_array_0_ren  = 1'b0;
    tag_array_1_wen  = 1'b0;
    tag_array_1_ren  = 1'b0;
    data_array_wen   = 1'b0;
    data_array_ren   = 1'b0;
    way_sel          = 1'b0;
    data_array_wben  = 16'h0000;
    amo_sel          = C_AMO_PASS;
    read_byte_sel    = 2'd0;
    memreq_type      = C_MEMREQ_READ;
    cacheresp_type   = 3'd0;
    line_wen         = 1'b0;
    line_way         = 1'b0;
    line_valid       = 1'b0;
    line_dirty       = 1'b0;
    lru_wen          = 1'b0;
    lru_wdata        = 1'b0;

    // Reset forces every output low regardless of the state register.
    if (!reset) begin
      read_byte_sel = cachereq_addr[3:2];
      case (state_q)
        ST_IDLE: begin
          cachereq_rdy = 1'b1;
          cachereq_en  = cachereq_val;
          if (cachereq_val) state_d = ST_TAG_CHECK;
        end
        ST_TAG_CHECK: begin
          tag_array_0_ren = 1'b1;
          tag_array_1_ren = 1'b1;
          hit0     = tag_match_0 & line_valid_r[0];
          hit1     = tag_match_1 & line_valid_r[1];
          victim_d = !line_valid_r[0] ? 1'b0 : (!line_valid_r[1] ? 1'b1 : lru_r);
          if (cachereq_type == C_TYPE_INIT) begin
            // Preload path: claim the victim without evicting it.
            tag_array_0_wen = ~victim_d;
            tag_array_1_wen = victim_d;
            way_sel    = victim_d;
            line_wen   = 1'b1;
            line_way   = victim_d;
            line_valid = 1'b1;
            line_dirty = 1'b1;
            hit_way_d  = victim_d;
            state_d    = ST_WRITE_ACCESS;
          end else if (hit0 | hit1) begin
            hit_way_d = hit1;
            lru_wen   = 1'b1;
            lru_wdata = ~hit1;
            if (cachereq_type == C_TYPE_WRITE)
              state_d = ST_WRITE_ACCESS;
            else if (cachereq_type == C_TYPE_AMO_ADD || cachereq_type == C_TYPE_AMO_AND ||
                     cachereq_type == C_TYPE_AMO_OR)
              state_d = ST_AMO_READ;
            else
              state_d = ST_READ_ACCESS;
          end else if (line_valid_r[victim_d] && line_dirty_r[victim_d]) begin
            state_d = ST_EVICT_PREPARE;
          end else begin
            state_d = ST_REFILL_REQUEST;
          end
        end
        ST_READ_ACCESS, ST_AMO_READ: begin
          data_array_ren   = 1'b1;
          way_sel          = hit_way_q;
          read_data_reg_en = 1'b1;
          state_d = (state_q == ST_AMO_READ) ? ST_AMO_WRITE : ST_WAIT;
        end
        ST_WRITE_ACCESS, ST_AMO_WRITE: begin
          data_array_wen  = 1'b1;
          way_sel         = hit_way_q;
          data_array_wben = word_wben(cachereq_addr[3:2]);
          line_wen        = 1'b1;
          line_way        = hit_way_q;
          line_valid      = 1'b1;
          line_dirty      = 1'b1;
          if (state_q == ST_AMO_WRITE) begin
            case (cachereq_type)
              C_TYPE_AMO_ADD: amo_sel = C_AMO_ADD;
              C_TYPE_AMO_AND: amo_sel = C_AMO_AND;
              C_TYPE_AMO_OR:  amo_sel = C_AMO_OR;
              default:        amo_sel = C_AMO_PASS;
            endcase
          end
          state_d = ST_WAIT;
        end
        ST_EVICT_PREPARE: begin
          way_sel          = victim_q;
          tag_array_0_ren  = 1'b1;
          tag_array_1_ren  = 1'b1;
          data_array_ren   = 1'b1;
          read_data_reg_en = 1'b1;
          read_tag_reg_en  = 1'b1;
          state_d = ST_EVICT_REQUEST;
        end
        ST_EVICT_REQUEST: begin
          way_sel     = victim_q;
          memreq_val  = 1'b1;
          memreq_type = C_MEMREQ_WRITE;
          if (memreq_rdy) state_d = ST_EVICT_WAIT;
        end
        ST_EVICT_WAIT: begin
          memresp_rdy = 1'b1;
          if (memresp_val) state_d = ST_REFILL_REQUEST;
        end
        ST_REFILL_REQUEST: begin
          way_sel     = victim_q;
          memreq_val  = 1'b1;
          memreq_type = C_MEMREQ_READ;
          if (memreq_rdy) state_d = ST_REFILL_WAIT;
        end
        ST_REFILL_WAIT: begin
          memresp_rdy = 1'b1;
          memresp_en  = memresp_val;
          if (memresp_val) state_d = ST_REFILL_UPDATE;
        end
        ST_REFILL_UPDATE: begin
          way_sel         = victim_q;
          is_refill       = 1'b1;
          data_array_wen  = 1'b1;
          data_array_wben = 16'hFFFF;
          tag_array_0_wen = ~victim_q;
          tag_array_1_wen = victim_q;
          line_wen        = 1'b1;
          line_way        = victim_q;
          line_valid      = 1'b1;
          line_dirty      = 1'b0;
          state_d = ST_TAG_CHECK;
        end
        ST_WAIT: begin
          cacheresp_val  = 1'b1;
          cacheresp_type = cachereq_type;
          if (cacheresp_rdy) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_plab3_mem_blocking_cache_alt_ctrl.sv
// ----------------------------------------------------------------------------
// tb_plab3_mem_blocking_cache_alt_ctrl: directed bench with a tag-array and memory stand-in
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_plab3_mem_blocking_cache_alt_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cachereq_val, cachereq_rdy, cacheresp_val, cacheresp_rdy;
  logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [2:0]  cachereq_type;
  logic [31:0] cachereq_addr;
  logic        tag_match_0, tag_match_1;
  logic        cachereq_en, memresp_en, is_refill, read_data_reg_en, read_tag_reg_en;
  logic        tag_array_0_wen, tag_array_0_ren, tag_array_1_wen, tag_array_1_ren;
  logic        data_array_wen, data_array_ren, way_sel;
  logic [15:0] data_array_wben;
  logic [1:0]  amo_sel, read_byte_sel;
  logic [2:0]  memreq_type, cacheresp_type;

  int   n_chk  = 0;
  int   n_pass = 0;
  logic pend   = 1'b0;

  logic [24:0] btag [8][2];
  logic        bval [8][2];
  logic [2:0]  bidx;

  always #5 clk = ~clk;

  assign bidx        = cachereq_addr[6:4];
  assign tag_match_0 = bval[bidx][0] && (btag[bidx][0] == cachereq_addr[31:7]);
  assign tag_match_1 = bval[bidx][1] && (btag[bidx][1] == cachereq_addr[31:7]);

  plab3_mem_blocking_cache_alt_ctrl #(.p_idx_shamt(0), .p_opaque_nbits(8)) dut (
    .clk(clk), .reset(reset),
    .cachereq_val(cachereq_val), .cachereq_rdy(cachereq_rdy),
    .cacheresp_val(cacheresp_val), .cacheresp_rdy(cacheresp_rdy),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .cachereq_type(cachereq_type), .cachereq_addr(cachereq_addr),
    .tag_match_0(tag_match_0), .tag_match_1(tag_match_1),
    .cachereq_en(cachereq_en), .memresp_en(memresp_en), .is_refill(is_refill),
    .read_data_reg_en(read_data_reg_en), .read_tag_reg_en(read_tag_reg_en),
    .tag_array_0_wen(tag_array_0_wen), .tag_array_0_ren(tag_array_0_ren),
    .tag_array_1_wen(tag_array_1_wen), .tag_array_1_ren(tag_array_1_ren),
    .data_array_wen(data_array_wen), .data_array_ren(data_array_ren),
    .way_sel(way_sel), .data_array_wben(data_array_wben), .amo_sel(amo_sel),
    .read_byte_sel(read_byte_sel), .memreq_type(memreq_type),
    .cacheresp_type(cacheresp_type)
  );

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
  endtask

  // One clock: tag stand-in captures writes, zero-wait memory answers one cycle after a request.
  task automatic tick();
    logic mfire, rfire;
    #1;
    mfire = memreq_val && memreq_rdy;
    rfire = memresp_val && memresp_rdy;
    if (tag_array_0_wen) begin btag[bidx][0] = cachereq_addr[31:7]; bval[bidx][0] = 1'b1; end
    if (tag_array_1_wen) begin btag[bidx][1] = cachereq_addr[31:7]; bval[bidx][1] = 1'b1; end
    @(posedge clk);
    #1;
    if (rfire) pend = 1'b0;
    if (mfire) pend = 1'b1;
    memresp_val = pend;
  endtask

  task automatic do_reset();
    reset = 1'b1; cachereq_val = 1'b0; memresp_val = 1'b0; pend = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // seq encodes memreq order: each request appends (type+1) as a decimal digit.
  task automatic xact(input string nm, input logic [2:0] typ, input logic [31:0] addr,
                      input int exp_lat, input int exp_seq, input logic exp_way,
                      input logic [15:0] exp_wben, input logic [1:0] exp_amo);
    int   lat    = -1;
    int   seq    = 0;
    logic saw_wr = 1'b0;
    cachereq_val = 1'b1; cachereq_type = typ; cachereq_addr = addr;
    cacheresp_rdy = 1'b1; memreq_rdy = 1'b1;
    #1;
    chk({nm, "_accept"}, {31'd0, cachereq_rdy}, 32'd1);
    tick();
    cachereq_val = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      #1;
      if (memreq_val) seq = seq * 10 + int'(memreq_type) + 1;
      if (read_tag_reg_en) chk({nm, "_evict_way"}, {31'd0, way_sel}, {31'd0, exp_way});
      else if (data_array_ren) chk({nm, "_read_way"}, {31'd0, way_sel}, {31'd0, exp_way});
      if (data_array_wen && is_refill) begin
        chk({nm, "_refill_way"}, {31'd0, way_sel}, {31'd0, exp_way});
        chk({nm, "_refill_wben"}, {16'd0, data_array_wben}, 32'h0000FFFF);
      end
      if (data_array_wen && !is_refill) begin
        saw_wr = 1'b1;
        chk({nm, "_wr_way"}, {31'd0, way_sel}, {31'd0, exp_way});
        chk({nm, "_wben"}, {16'd0, data_array_wben}, {16'd0, exp_wben});
        chk({nm, "_amo_sel"}, {30'd0, amo_sel}, {30'd0, exp_amo});
      end
      if (cacheresp_val) begin
        lat = c;
        chk({nm, "_resp_type"}, {29'd0, cacheresp_type}, {29'd0, typ});
      end
      tick();
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_memreq_seq"}, seq, exp_seq);
    chk({nm, "_data_write"}, {31'd0, saw_wr}, {31'd0, (typ != 3'd0)});
  endtask

  initial begin
    for (int s = 0; s < 8; s++) begin
      bval[s][0] = 1'b0; bval[s][1] = 1'b0; btag[s][0] = '0; btag[s][1] = '0;
    end
    reset = 1'b1; cachereq_val = 1'b1; cachereq_type = 3'd0; cachereq_addr = 32'h0;
    cacheresp_rdy = 1'b1; memreq_rdy = 1'b1; memresp_val = 1'b1;

    // Reset: everything low even with requests pending at the boundary.
    tick(); tick();
    chk("rst_cachereq_rdy", {31'd0, cachereq_rdy}, 32'd0);
    chk("rst_cachereq_en", {31'd0, cachereq_en}, 32'd0);
    chk("rst_memresp_rdy", {31'd0, memresp_rdy}, 32'd0);
    chk("rst_memresp_en", {31'd0, memresp_en}, 32'd0);
    cachereq_val = 1'b0; memresp_val = 1'b0; reset = 1'b0;
    #1;
    chk("post_rst_rdy", {31'd0, cachereq_rdy}, 32'd1);

    // Cold read, write hit, read hit, three AMO hits on the 0x1000 line.
    xact("cold_rd_1000", 3'd0, 32'h1000, 7, 1, 1'b0, 16'h0000, 2'd0);
    xact("wr_1004",      3'd1, 32'h1004, 3, 0, 1'b0, 16'h00F0, 2'd0);
    xact("rd_1004",      3'd0, 32'h1004, 3, 0, 1'b0, 16'h0000, 2'd0);
    xact("amo_add_1008", 3'd3, 32'h1008, 4, 0, 1'b0, 16'h0F00, 2'd1);
    xact("amo_and_100c", 3'd4, 32'h100C, 4, 0, 1'b0, 16'hF000, 2'd2);
    xact("amo_or_1000",  3'd5, 32'h1000, 4, 0, 1'b0, 16'h000F, 2'd3);

    // Memory request backpressure, then reset while waiting for refill data.
    memreq_rdy = 1'b0;
    cachereq_val = 1'b1; cachereq_type = 3'd0; cachereq_addr = 32'h2010;
    #1; tick(); cachereq_val = 1'b0;
    #1; chk("bp_tc_no_memreq", {31'd0, memreq_val}, 32'd0); tick();
    for (int i = 0; i < 5; i++) begin
      #1; chk("bp_memreq_held", {31'd0, memreq_val}, 32'd1); tick();
    end
    memreq_rdy = 1'b1;
    #1; chk("bp_memreq_type", {29'd0, memreq_type}, 32'd0); tick();
    #1; chk("bp_refill_wait_rdy", {31'd0, memresp_rdy}, 32'd1);
    reset = 1'b1; pend = 1'b0; memresp_val = 1'b0;
    #1;
    chk("midrst_outputs", {28'd0, cachereq_rdy, memresp_rdy, memreq_val, cacheresp_val}, 32'd0);
    tick(); reset = 1'b0;
    #1;
    chk("midrst_idle", {31'd0, cachereq_rdy}, 32'd1);
    chk("midrst_no_memreq", {31'd0, memreq_val}, 32'd0);

    // Stale tag still matches in the stand-in, but valid bits were cleared.
    xact("empty_rd_1000", 3'd0, 32'h1000, 7, 1, 1'b0, 16'h0000, 2'd0);

    // Response backpressure on a hit.
    cacheresp_rdy = 1'b0;
    cachereq_val = 1'b1; cachereq_type = 3'd0; cachereq_addr = 32'h1000;
    #1; tick(); cachereq_val = 1'b0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      #1; chk("bp_resp_held", {31'd0, cacheresp_val}, 32'd1); tick();
    end
    cacheresp_rdy = 1'b1;
    #1; chk("bp_resp_val", {31'd0, cacheresp_val}, 32'd1); tick();
    #1;
    chk("bp_resp_done", {31'd0, cacheresp_val}, 32'd0);
    chk("bp_back_idle", {31'd0, cachereq_rdy}, 32'd1);

    // LRU replacement and dirty eviction within set 0.
    do_reset();
    xact("fill_0000",   3'd0, 32'h0000, 7,  1,  1'b0, 16'h0000, 2'd0);
    xact("fill_0080",   3'd0, 32'h0080, 7,  1,  1'b1, 16'h0000, 2'd0);
    xact("hit_0000",    3'd0, 32'h0000, 3,  0,  1'b0, 16'h0000, 2'd0);
    xact("lru_0100",    3'd0, 32'h0100, 7,  1,  1'b1, 16'h0000, 2'd0);
    xact("wr_0000",     3'd1, 32'h0000, 3,  0,  1'b0, 16'h000F, 2'd0);
    xact("wr_0100",     3'd1, 32'h0100, 3,  0,  1'b1, 16'h000F, 2'd0);
    xact("dirty_0080",  3'd0, 32'h0080, 10, 21, 1'b0, 16'h0000, 2'd0);
    xact("winit_0300",  3'd2, 32'h0300, 3,  0,  1'b1, 16'h000F, 2'd0);
    xact("rd_0300",     3'd0, 32'h0300, 3,  0,  1'b1, 16'h0000, 2'd0);

    // A stray memory response while idle must not be accepted.
    memresp_val = 1'b1;
    #1;
    chk("stray_memresp_rdy", {31'd0, memresp_rdy}, 32'd0);
    chk("stray_memresp_en", {31'd0, memresp_en}, 32'd0);
    memresp_val = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/plab3_mem_blocking_cache_alt_ctrl.md
# plab3_mem_blocking_cache_alt_ctrl

FSM control unit for the 2-way set-associative, write-back, write-allocate blocking cache (256 B, 16 B lines, 8 sets x 2 ways). It sequences the alternative blocking-cache datapath: tag check, data access, AMO read-modify-write, dirty eviction and refill. It owns the per-line valid/dirty bits and the per-set LRU bit, and drives the four val/rdy handshakes at the cache boundary.

## Interface
- p_idx_shamt, 0, left shift of the 3-bit set index within the address; index = cachereq_addr[4+p_idx_shamt +: 3]
- p_opaque_nbits, 8, opaque width; only passes through the datapath
- clk  in  1  clock
- reset  in  1  reset; one clock, synchronous, active-high
- cachereq_val/cachereq_rdy  in/out  1  cache request handshake
- cacheresp_val/cacheresp_rdy  out/in  1  cache response handshake
- memreq_val/memreq_rdy  out/in  1  memory request handshake
- memresp_val/memresp_rdy  in/out  1  memory response handshake
- cachereq_type  in  3  registered request type: 0 read, 1 write, 2 write-init, 3 amo.add, 4 amo.and, 5 amo.or
- cachereq_addr  in  32  registered request address
- tag_match_0, tag_match_1  in  1  tag compare results per way
- cachereq_en, memresp_en, is_refill, read_data_reg_en, read_tag_reg_en  out  1  datapath enables
- tag_array_0_wen/ren, tag_array_1_wen/ren, data_array_wen/ren, way_sel  out  1  array controls
- data_array_wben  out  16  byte write enables
- amo_sel  out  2  0 pass, 1 add, 2 and, 3 or
- read_byte_sel  out  2  word select = cachereq_addr[3:2]
- memreq_type  out  3  0 read (refill), 1 write (evict)
- cacheresp_type  out  3  echoes cachereq_type

## Operation
- States: IDLE, TAG_CHECK, READ_ACCESS, WRITE_ACCESS, AMO_READ, AMO_WRITE, EVICT_PREPARE, EVICT_REQUEST, EVICT_WAIT, REFILL_REQUEST, REFILL_WAIT, REFILL_UPDATE, WAIT.
- IDLE: cachereq_rdy=1; cachereq_en=cachereq_val; on fire -> TAG_CHECK.
- TAG_CHECK: both tag ren=1. hit0 = tag_match_0 & valid[idx][0]; hit1 likewise. Register hit_way (=hit1) and victim (first invalid way, way 0 before way 1; otherwise lru[idx]).
  - Type 2 (write-init): write tag to victim, valid=1, dirty=1, no eviction -> WRITE_ACCESS. For cold-cache preloading only.
  - Hit: read -> READ_ACCESS; write -> WRITE_ACCESS; AMO -> AMO_READ. Set lru[idx] = ~hit_way.
  - Miss with victim valid & dirty -> EVICT_PREPARE; otherwise -> REFILL_REQUEST.
- READ_ACCESS: data ren, way_sel=hit_way, read_data_reg_en -> WAIT.
- WRITE_ACCESS: data wen, is_refill=0, amo_sel=0, wben = 16'hF << 4*addr[3:2]; dirty=1 -> WAIT.
- AMO_READ: as READ_ACCESS -> AMO_WRITE. AMO_WRITE: write as WRITE_ACCESS with amo_sel=type-2 -> WAIT. The response returns the old word.
- EVICT_PREPARE: way_sel=victim; tag ren, data ren, read_data_reg_en, read_tag_reg_en -> EVICT_REQUEST.
- EVICT_REQUEST: memreq_val, type 1; hold until rdy -> EVICT_WAIT. EVICT_WAIT: memresp_rdy=1; on val -> REFILL_REQUEST.
- REFILL_REQUEST: memreq_val, type 0 -> REFILL_WAIT on rdy. REFILL_WAIT: memresp_rdy=1, memresp_en=memresp_val; on val -> REFILL_UPDATE.
- REFILL_UPDATE: way_sel=victim, is_refill=1, data wen, wben=16'hFFFF, victim tag wen; valid=1, dirty=0 -> TAG_CHECK. The re-check now hits.
- WAIT: cacheresp_val=1; on rdy -> IDLE.
- All outputs not named for a state are 0.

## Timing
- Reset: state=IDLE; all valid/dirty/lru=0; every output 0 while reset is high. cachereq_rdy rises the first cycle after reset deasserts.
- Hit: request accepted in cycle 0; cacheresp_val in cycle 3 (TAG_CHECK, ACCESS, WAIT). AMO hit: cycle 4.
- Clean miss with zero-wait memory: memreq_val in cycle 2, refill data in cycle 3, cacheresp_val in cycle 7. A dirty miss adds 3 cycles.
- val is held stable until rdy; handshake signals never combinationally depend on their own partner's rdy.
- Reset mid-miss abandons the transaction. No partial-line state survives.
- Only one outstanding memory request at a time. A memresp arriving outside the wait states is not accepted (memresp_rdy=0).

## Structure
- Shared package: state encodings, message-type constants, amo_sel codes, memreq type codes.
- Sub-module plab3_mem_cache_line_state holds valid[8][2], dirty[8][2] and lru[8]. It provides a registered write port plus combinational lookup by idx, and resets synchronously.

## Test plan
- Cold read of 0x1000 -> one memreq read at addr 0x1000, refill, response data = memory word.
- Write 0xdeadbeef to 0x1004, then read 0x1004 -> no memreq; read returns 0xdeadbeef with 3-cycle latency.
- Fill both ways of set 0 (0x0000, 0x0080), read 0x0000, then access 0x0100 -> way 1 (LRU) evicted.
- Dirty eviction: write 0x0000 and 0x0080, then read 0x0100 -> memreq write of line 0x0000 precedes memreq read of 0x0100.
- amo.add 5 to a word holding 10 -> response 10; subsequent read returns 15. amo.and and amo.or checked the same way.
- Backpressure: hold memreq_rdy and cacheresp_rdy low for 5 cycles -> val stays high; assert reset mid-refill -> IDLE, cache empty.
